// File: rtl/alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// alu_cmd_seq
//
// Queues ALU commands, issues them one per cycle to an external ALU and
// collects the ALU results into a response FIFO, delivered in issue order.
// Issue is credit-limited: a command may only be issued when the number of
// results still owed (in flight in the ALU plus buffered in the response
// FIFO) is below RSP_DEPTH. This guarantees the response FIFO never
// overflows, even though the ALU result cannot be back-pressured.
//
// Parameters
//   CMD_DEPTH    command FIFO entries (power of 2, >= 2)
//   RSP_DEPTH    response FIFO entries (power of 2, >= 2)
//   ALU_LATENCY  cycles from the ALU sampling an opcode to its result
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid    command offered
//   cmd_ready    command FIFO not full (independent of cmd_valid)
//   cmd_opcode   opcode of offered command
//   cmd_data     operand of offered command
//   alu_opcode   registered opcode to the ALU, 4'h0 (NOP) when not issuing
//   alu_data     registered operand to the ALU, 8'h00 when not issuing
//   alu_result   ALU result byte
//   rsp_valid    response FIFO non-empty
//   rsp_ready    consumer accepts the head response
//   rsp_data     head response byte, 8'h00 while empty
//   issued_count (only with ALU_CMD_SEQ_STATUS_EN) issues since reset,
//                wrapping 8 bit counter
//
// Configuration macro
//   ALU_CMD_SEQ_STATUS_EN  adds the issued_count output and its counter
// ---------------------------------------------------------------------------
module alu_cmd_seq #(
  parameter int CMD_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opcode,
  input  logic [7:0] cmd_data,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_data,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data
`ifdef ALU_CMD_SEQ_STATUS_EN
  ,
  output logic [7:0] issued_count
`endif
);

  localparam int CPW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int RCW = $clog2(RSP_DEPTH + 1);

  // Command FIFO storage and bookkeeping
  logic [11:0]    cmdMem_q [CMD_DEPTH];
  logic [CPW-1:0] cmdWrPtr_q, cmdWrPtr_d;
  logic [CPW-1:0] cmdRdPtr_q, cmdRdPtr_d;
  logic [CCW-1:0] cmdCnt_q, cmdCnt_d;

  // Response FIFO storage and bookkeeping
  logic [7:0]     rspMem_q [RSP_DEPTH];
  logic [RPW-1:0] rspWrPtr_q, rspWrPtr_d;
  logic [RPW-1:0] rspRdPtr_q, rspRdPtr_d;
  logic [RCW-1:0] rspCnt_q, rspCnt_d;

  // Results owed: commands in the ALU pipeline plus buffered responses
  logic [RCW-1:0] credit_q, credit_d;

  // One bit per pipeline stage; bit ALU_LATENCY marks a result on alu_result
  logic [ALU_LATENCY:0] inflight_q, inflight_d;
  logic [ALU_LATENCY:0] inflightShift;

  logic [3:0] aluOpcode_q, aluOpcode_d;
  logic [7:0] aluData_q, aluData_d;

  logic cmdPush;
  logic issue;
  logic capture;
  logic rspPop;

  assign cmd_ready  = (cmdCnt_q != CCW'(CMD_DEPTH));
  assign rsp_valid  = (rspCnt_q != '0);
  assign rsp_data   = rsp_valid ? rspMem_q[rspRdPtr_q] : 8'h00;
  assign alu_opcode = aluOpcode_q;
  assign alu_data   = aluData_q;

  // The shift register slice does not exist when the ALU is combinational
  generate
    if (ALU_LATENCY == 0) begin : gShiftComb
      assign inflightShift = issue;
    end else begin : gShiftPipe
      assign inflightShift = {inflight_q[ALU_LATENCY-1:0], issue};
    end
  endgenerate

  // Next-state logic. Issue only looks at registered state, so a command
  // written this edge is issuable next edge at the earliest, and a pop only
  // frees credit for the following edge.
  always_comb begin
    cmdPush     = cmd_valid && cmd_ready;
    issue       = (cmdCnt_q != '0) && (credit_q < RCW'(RSP_DEPTH));
    capture     = inflight_q[ALU_LATENCY];
    rspPop      = rsp_valid && rsp_ready;

    cmdWrPtr_d  = cmdWrPtr_q;
    cmdRdPtr_d  = cmdRdPtr_q;
    cmdCnt_d    = cmdCnt_q;
    rspWrPtr_d  = rspWrPtr_q;
    rspRdPtr_d  = rspRdPtr_q;
    rspCnt_d    = rspCnt_q;
    credit_d    = credit_q;
    inflight_d  = inflightShift;
    aluOpcode_d = 4'h0;
    aluData_d   = 8'h00;

    if (cmdPush) begin
      cmdWrPtr_d = cmdWrPtr_q + CPW'(1);
    end
    if (issue) begin
      cmdRdPtr_d  = cmdRdPtr_q + CPW'(1);
      aluOpcode_d = cmdMem_q[cmdRdPtr_q][11:8];
      aluData_d   = cmdMem_q[cmdRdPtr_q][7:0];
    end
    unique case ({cmdPush, issue})
      2'b10:   cmdCnt_d = cmdCnt_q + CCW'(1);
      2'b01:   cmdCnt_d = cmdCnt_q - CCW'(1);
      default: cmdCnt_d = cmdCnt_q;
    endcase

    if (capture) begin
      rspWrPtr_d = rspWrPtr_q + RPW'(1);
    end
    if (rspPop) begin
      rspRdPtr_d = rspRdPtr_q + RPW'(1);
    end
    unique case ({capture, rspPop})
      2'b10:   rspCnt_d = rspCnt_q + RCW'(1);
      2'b01:   rspCnt_d = rspCnt_q - RCW'(1);
      default: rspCnt_d = rspCnt_q;
    endcase

    // A capture only moves a result from the pipeline into the FIFO, so
    // credit changes on issue and pop alone
    unique case ({issue, rspPop})
      2'b10:   credit_d = credit_q + RCW'(1);
      2'b01:   credit_d = credit_q - RCW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdWrPtr_q  <= '0;
      cmdRdPtr_q  <= '0;
      cmdCnt_q    <= '0;
      rspWrPtr_q  <= '0;
      rspRdPtr_q  <= '0;
      rspCnt_q    <= '0;
      credit_q    <= '0;
      inflight_q  <= '0;
      aluOpcode_q <= 4'h0;
      aluData_q   <= 8'h00;
    end else begin
      cmdWrPtr_q  <= cmdWrPtr_d;
      cmdRdPtr_q  <= cmdRdPtr_d;
      cmdCnt_q    <= cmdCnt_d;
      rspWrPtr_q  <= rspWrPtr_d;
      rspRdPtr_q  <= rspRdPtr_d;
      rspCnt_q    <= rspCnt_d;
      credit_q    <= credit_d;
      inflight_q  <= inflight_d;
      aluOpcode_q <= aluOpcode_d;
      aluData_q   <= aluData_d;
    end
  end

  // FIFO storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (cmdPush) begin
      cmdMem_q[cmdWrPtr_q] <= {cmd_opcode, cmd_data};
    end
    if (capture) begin
      rspMem_q[rspWrPtr_q] <= alu_result;
    end
  end

`ifdef ALU_CMD_SEQ_STATUS_EN
  logic [7:0] issuedCount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issuedCount_q <= 8'h00;
    end else if (issue) begin
      issuedCount_q <= issuedCount_q + 8'h01;
    end
  end

  assign issued_count = issuedCount_q;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_seq
//
// Directed and randomized stimulus for alu_cmd_seq. A behavioural model keeps
// queues of accepted commands, results in the ALU and buffered responses and
// predicts handshakes, ALU outputs and response data each cycle. The bench
// also provides the ALU itself (one cycle latency).
// ---------------------------------------------------------------------------
module tb_alu_cmd_seq;

  localparam int CMD_DEPTH   = 4;
  localparam int RSP_DEPTH   = 4;
  localparam int ALU_LATENCY = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_opcode = 4'h0;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] alu_opcode;
  logic [7:0] alu_data;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
`ifdef ALU_CMD_SEQ_STATUS_EN
  logic [7:0] issued_count;
`endif

  alu_cmd_seq #(
    .CMD_DEPTH  (CMD_DEPTH),
    .RSP_DEPTH  (RSP_DEPTH),
    .ALU_LATENCY(ALU_LATENCY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_data    (cmd_data),
    .alu_opcode  (alu_opcode),
    .alu_data    (alu_data),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data)
`ifdef ALU_CMD_SEQ_STATUS_EN
    ,
    .issued_count(issued_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] aluFn(input logic [3:0] op, input logic [7:0] d);
    return d + {op, op};
  endfunction

  // The ALU: samples opcode/operand at a rising edge, result valid one cycle
  // later
  logic [7:0] aluRes = 8'h00;
  always @(posedge clk) aluRes <= aluFn(alu_opcode, alu_data);
  assign alu_result = aluRes;

  typedef struct {
    logic [3:0] op;
    logic [7:0] d;
  } cmd_t;

  typedef struct {
    logic [7:0] r;
    int         due;
  } flight_t;

  cmd_t       cmdQ[$];
  flight_t    flight[$];
  logic [7:0] rspQ[$];
  int         edgeNo = 0;
  int         mIssued = 0;

  int obsAccepted = 0;
  int obsIssued = 0;
  int obsPopped = 0;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, predict what the
  // edge does, then check the post-edge ALU outputs
  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [7:0] d, input logic rdy);
    logic       doAccept;
    logic       doIssue;
    logic       doPop;
    logic [3:0] expOp;
    logic [7:0] expD;
    cmd_t       c;
    flight_t    f;
    int         outstanding;

    cmd_valid  = v;
    cmd_opcode = op;
    cmd_data   = d;
    rsp_ready  = rdy;

    outstanding = flight.size() + rspQ.size();
    checkOutput("cmd_ready", cmd_ready, cmdQ.size() < CMD_DEPTH);
    checkOutput("rsp_valid", rsp_valid, rspQ.size() > 0);
    if (rspQ.size() > 0) checkOutput("rsp_data", rsp_data, rspQ[0]);
    else checkOutput("rsp_data_idle", rsp_data, 8'h00);

    doAccept = v && (cmdQ.size() < CMD_DEPTH);
    doIssue  = (cmdQ.size() > 0) && (outstanding < RSP_DEPTH);
    doPop    = rdy && (rspQ.size() > 0);
    if (cmd_valid && cmd_ready) obsAccepted++;
    if (rsp_valid && rsp_ready) obsPopped++;

    @(posedge clk);
    edgeNo++;
    #1;

    if (doPop) void'(rspQ.pop_front());
    if (flight.size() > 0 && flight[0].due == edgeNo) begin
      rspQ.push_back(flight[0].r);
      void'(flight.pop_front());
    end
    expOp = 4'h0;
    expD  = 8'h00;
    if (doIssue) begin
      c     = cmdQ.pop_front();
      expOp = c.op;
      expD  = c.d;
      f.r   = aluFn(c.op, c.d);
      f.due = edgeNo + 1 + ALU_LATENCY;
      flight.push_back(f);
      mIssued++;
    end
    if (doAccept) begin
      c.op = op;
      c.d  = d;
      cmdQ.push_back(c);
    end

    checkOutput("alu_opcode", alu_opcode, expOp);
    checkOutput("alu_data", alu_data, expD);
    if (alu_opcode != 4'h0) obsIssued++;
`ifdef ALU_CMD_SEQ_STATUS_EN
    checkOutput("issued_count", issued_count, mIssued % 256);
`endif
  endtask

  // Assert reset between edges, check the asynchronous clear, hold for two
  // edges and release between edges
  task automatic resetDut();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_data", rsp_data, 8'h00);
    checkOutput("rst_alu_opcode", alu_opcode, 4'h0);
    checkOutput("rst_alu_data", alu_data, 8'h00);
`ifdef ALU_CMD_SEQ_STATUS_EN
    checkOutput("rst_issued_count", issued_count, 8'h00);
`endif
    cmdQ.delete();
    flight.delete();
    rspQ.delete();
    mIssued = 0;
    @(posedge clk);
    edgeNo++;
    @(posedge clk);
    edgeNo++;
    #1;
    rst_n = 1'b1;
  endtask

  // Idle with rsp_ready high until the model holds nothing, bounded
  task automatic drain();
    int n;
    n = 0;
    while ((cmdQ.size() + flight.size() + rspQ.size()) != 0 && n < 80) begin
      applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
      n++;
    end
    checkOutput("drain_bound", (cmdQ.size() + flight.size() + rspQ.size()) == 0, 1'b1);
    checkOutput("drain_rsp_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int baseAcc;
    int baseIss;
    int basePop;

    #1;
    resetDut();

    // Single command: issued one edge after acceptance, result two edges later
    $display("[TB] single command");
    applyStimulus(1'b1, 4'h3, 8'h5A, 1'b1);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    checkOutput("single_alu_opcode", alu_opcode, 4'h3);
    checkOutput("single_alu_data", alu_data, 8'h5A);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    checkOutput("single_alu_nop", alu_opcode, 4'h0);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    checkOutput("single_rsp_valid", rsp_valid, 1'b1);
    checkOutput("single_rsp_data", rsp_data, 8'h8D);
    drain();

    // Credit stall: six commands with the consumer stalled
    $display("[TB] credit stall");
    baseIss = obsIssued;
    basePop = obsPopped;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i + 1), 8'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
    checkOutput("stall_issued", obsIssued - baseIss, 4);
    checkOutput("stall_cmd_ready", cmd_ready, 1'b1);
    drain();
    checkOutput("stall_issued_total", obsIssued - baseIss, 6);
    checkOutput("stall_popped", obsPopped - basePop, 6);

    // Fill both FIFOs until back-pressure
    $display("[TB] full back-pressure");
    baseAcc = obsAccepted;
    baseIss = obsIssued;
    basePop = obsPopped;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'($urandom_range(1, 15)), 8'($urandom), 1'b0);
    checkOutput("full_accepted", obsAccepted - baseAcc, 8);
    checkOutput("full_issued", obsIssued - baseIss, 4);
    checkOutput("full_cmd_ready", cmd_ready, 1'b0);
    drain();
    checkOutput("full_popped", obsPopped - basePop, 8);

    // Reset in the middle of a burst
    $display("[TB] reset mid-burst");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'($urandom_range(1, 15)), 8'($urandom), 1'b0);
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    checkOutput("post_reset_rsp_valid", rsp_valid, 1'b0);
    applyStimulus(1'b1, 4'h9, 8'hC3, 1'b1);
    drain();

    // Random traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(1, 15)), 8'($urandom),
                    $urandom_range(0, 2) != 0);
    end
    drain();

    // 257 issues from reset
    $display("[TB] 257 issues");
    resetDut();
    baseIss = obsIssued;
    for (int i = 0; i < 257; i++) applyStimulus(1'b1, 4'($urandom_range(1, 15)), 8'($urandom), 1'b1);
    drain();
    checkOutput("issued_257", obsIssued - baseIss, 257);
`ifdef ALU_CMD_SEQ_STATUS_EN
    checkOutput("issued_count_wrap", issued_count, 8'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
